lsu_pipe: RTL and testbench

Parametrised, clocked successor to the combinational load/store unit. It accepts one LB/LW/SB/SW per handshake from the LSQ issue port and drives a valid/ready data-memory request channel. It waits for variable-latency read responses and presents a registered completion (tag, PC, data, flags) to the CDB/ROB. It also handles LSQ store-to-load forwarding, byte-lane alignment, sign extension, misalignment detection and pipeline flush with in-flight response draining.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 32 +++
 rtl/lsu_pipe.sv | 177 +++++++++++++++++
 tb/tb_lsu_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the pipelined load/store unit.
//   - op encodings for LB/LW/SB/SW as issued by the LSQ
//   - FSM state enum for lsu_pipe
//   - is_ls(): true for the four memory ops; anything else is dropped
package lsu_pkg;

    localparam logic [3:0] OP_LB = 4'd7;
    localparam logic [3:0] OP_LW = 4'd8;
    localparam logic [3:0] OP_SB = 4'd9;
    localparam logic [3:0] OP_SW = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_CMP   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    function automatic logic is_ls(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LW) || (op == OP_SB) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering.
//   inputs : is_byte, is_store, off (byte offset in word), store_data, word
//   outputs: be (byte enables), wdata (store data placed on lanes),
//            load_data (byte extracted + sign-extended, or full word)
module lsu_lane_align #(
    parameter int XLEN  = 32,
    parameter int NB    = XLEN / 8,
    parameter int OFF_W = $clog2(NB)
) (
    input  logic             is_byte,
    input  logic             is_store,
    input  logic [OFF_W-1:0] off,
    input  logic [XLEN-1:0]  store_data,
    input  logic [XLEN-1:0]  word,
    output logic [NB-1:0]    be,
    output logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  load_data
);
    logic [OFF_W+2:0] bit_off;
    logic [7:0]       sel_byte;
    logic [NB-1:0]    one_hot;

    assign bit_off  = {off, 3'b000};
    assign sel_byte = word[bit_off +: 8];
    assign one_hot  = {{(NB-1){1'b0}}, 1'b1} << off;

    // Only byte stores narrow the enables; loads always fetch the whole word.
    assign be        = (is_store && is_byte) ? one_hot : {NB{1'b1}};
    assign wdata     = is_byte ? {NB{store_data[7:0]}} : store_data;
    assign load_data = is_byte ? {{(XLEN-8){sel_byte[7]}}, sel_byte} : word;

endmodule

// File: rtl/lsu_pipe.sv
// lsu_pipe: clocked load/store unit between the LSQ issue port, a
// valid/ready data-memory channel and the CDB/ROB completion port.
//   issue_*   : one LB/LW/SB/SW per valid/ready handshake (+ LSQ forwarding)
//   mem_req_* : single outstanding word-aligned request, held until ready
//   mem_resp_*: variable-latency read data (loads only)
//   cmp_*     : registered completion held until cmp_ready
//   flush     : kills the current instruction; an in-flight load response
//               is drained in S_DRAIN before new work is accepted
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int PC_W   = 32,
    parameter int TAG_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        issue_op,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [PC_W-1:0]   issue_pc,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic [XLEN-1:0]   issue_store_data,
    input  logic              issue_fwd_hit,
    input  logic [XLEN-1:0]   issue_fwd_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN/8-1:0] mem_req_be,
    output logic [XLEN-1:0]   mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    output logic              cmp_valid,
    input  logic              cmp_ready,
    output logic [TAG_W-1:0]  cmp_tag,
    output logic [PC_W-1:0]   cmp_pc,
    output logic [XLEN-1:0]   cmp_data,
    output logic              cmp_is_store,
    output logic              cmp_from_lsq,
    output logic              cmp_misaligned
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_t            state;
    logic              byte_op, store_op;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   sdata_q;
    logic [PC_W-1:0]   pc_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   data_q;
    logic              is_store_q, from_lsq_q, misaligned_q;

    logic              iss_byte, iss_store;
    logic [OFF_W-1:0]  iss_off;

    assign iss_byte  = (issue_op == OP_LB) || (issue_op == OP_SB);
    assign iss_store = (issue_op == OP_SB) || (issue_op == OP_SW);
    assign iss_off   = issue_addr[OFF_W-1:0];

    // One aligner serves both paths: in IDLE it extracts forwarded data for
    // the instruction being accepted; otherwise it works on latched fields
    // (request lanes in REQ, response extract in WAIT).
    logic              sel_issue;
    logic              al_byte, al_store;
    logic [OFF_W-1:0]  al_off;
    logic [XLEN-1:0]   al_word, al_wdata, al_load;
    logic [NB-1:0]     al_be;

    assign sel_issue = (state == S_IDLE);
    assign al_byte   = sel_issue ? iss_byte       : byte_op;
    assign al_store  = sel_issue ? iss_store      : store_op;
    assign al_off    = sel_issue ? iss_off        : off_q;
    assign al_word   = sel_issue ? issue_fwd_data : mem_resp_rdata;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .is_byte    (al_byte),
        .is_store   (al_store),
        .off        (al_off),
        .store_data (sdata_q),
        .word       (al_word),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            byte_op      <= 1'b0;
            store_op     <= 1'b0;
            off_q        <= '0;
            addr_q       <= '0;
            sdata_q      <= '0;
            pc_q         <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            is_store_q   <= 1'b0;
            from_lsq_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_valid && !flush && is_ls(issue_op)) begin
                        byte_op      <= iss_byte;
                        store_op     <= iss_store;
                        off_q        <= iss_off;
                        addr_q       <= {issue_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        sdata_q      <= issue_store_data;
                        pc_q         <= issue_pc;
                        tag_q        <= issue_tag;
                        data_q       <= '0;
                        is_store_q   <= iss_store;
                        from_lsq_q   <= 1'b0;
                        misaligned_q <= 1'b0;
                        if (!iss_byte && iss_off != '0) begin
                            misaligned_q <= 1'b1;
                            state        <= S_CMP;
                        end else if (!iss_store && issue_fwd_hit) begin
                            data_q     <= al_load;
                            from_lsq_q <= 1'b1;
                            state      <= S_CMP;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        // A store that already handshook is committed even if flushed.
                        if (store_op) state <= flush ? S_IDLE : S_CMP;
                        else          state <= flush ? S_DRAIN : S_WAIT;
                    end else if (flush) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= mem_resp_valid ? S_IDLE : S_DRAIN;
                    end else if (mem_resp_valid) begin
                        data_q <= al_load;
                        state  <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (flush || cmp_ready) state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (mem_resp_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign issue_ready    = (state == S_IDLE) && !flush && !rst;

    assign mem_req_valid  = (state == S_REQ);
    assign mem_req_we     = mem_req_valid && store_op;
    assign mem_req_addr   = mem_req_valid ? addr_q   : '0;
    assign mem_req_be     = mem_req_valid ? al_be    : '0;
    assign mem_req_wdata  = mem_req_valid ? al_wdata : '0;

    assign cmp_valid      = (state == S_CMP);
    assign cmp_tag        = tag_q;
    assign cmp_pc         = pc_q;
    assign cmp_data       = data_q;
    assign cmp_is_store   = is_store_q;
    assign cmp_from_lsq   = from_lsq_q;
    assign cmp_misaligned = misaligned_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe: directed bench for lsu_pipe (XLEN=32). Inputs are driven and
// outputs sampled on the falling edge; the bench plays the memory itself.
module tb_lsu_pipe;
    import lsu_pkg::*;

    logic        clk, rst, flush;
    logic        issue_valid, issue_ready;
    logic [3:0]  issue_op;
    logic [31:0] issue_addr, issue_pc, issue_store_data, issue_fwd_data;
    logic [5:0]  issue_tag;
    logic        issue_fwd_hit;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        cmp_valid, cmp_ready;
    logic [5:0]  cmp_tag;
    logic [31:0] cmp_pc, cmp_data;
    logic        cmp_is_store, cmp_from_lsq, cmp_misaligned;

    int total = 0;
    int bad   = 0;

    lsu_pipe #(.XLEN(32), .ADDR_W(32), .PC_W(32), .TAG_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_addr(issue_addr), .issue_pc(issue_pc),
        .issue_tag(issue_tag), .issue_store_data(issue_store_data),
        .issue_fwd_hit(issue_fwd_hit), .issue_fwd_data(issue_fwd_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
        .cmp_tag(cmp_tag), .cmp_pc(cmp_pc), .cmp_data(cmp_data),
        .cmp_is_store(cmp_is_store), .cmp_from_lsq(cmp_from_lsq),
        .cmp_misaligned(cmp_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] pc,
                         input logic [5:0] tag, input logic [31:0] sd,
                         input logic hit, input logic [31:0] fwd);
        issue_valid = 1'b1; issue_op = op; issue_addr = addr; issue_pc = pc;
        issue_tag = tag; issue_store_data = sd; issue_fwd_hit = hit; issue_fwd_data = fwd;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_op = 4'd0;
        issue_addr = '0; issue_pc = '0; issue_tag = '0; issue_store_data = '0;
        issue_fwd_hit = 1'b0; issue_fwd_data = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_rdata = '0; cmp_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_cmp_valid", cmp_valid, 0);
        chk("rst_cmp_tag",   cmp_tag, 0);
        chk("rst_cmp_data",  cmp_data, 0);
        chk("rst_issue_rdy", issue_ready, 0);
        rst = 1'b0;
        tick();
        chk("idle_issue_rdy", issue_ready, 1);

        // Non-LS op is accepted and dropped
        issue(4'd3, 32'h100, 32'h0, 6'd1, 32'h0, 1'b0, 32'h0);
        tick(); issue_valid = 1'b0;
        chk("nop_req_valid", mem_req_valid, 0);
        chk("nop_cmp_valid", cmp_valid, 0);
        chk("nop_issue_rdy", issue_ready, 1);

        // LW 0x104, response 3 cycles into WAIT
        issue(OP_LW, 32'h104, 32'h1000, 6'd5, 32'h0, 1'b0, 32'h0);
        tick(); issue_valid = 1'b0;
        chk("lw_req_valid", mem_req_valid, 1);
        chk("lw_req_addr",  mem_req_addr, 32'h104);
        chk("lw_req_be",    mem_req_be, 4'hF);
        chk("lw_req_we",    mem_req_we, 0);
        chk("lw_issue_rdy_req", issue_ready, 0);
        mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0;
        chk("lw_req_dropped", mem_req_valid, 0);
        tick(); chk("lw_wait1_cmp", cmp_valid, 0);
        tick(); chk("lw_wait2_rdy", issue_ready, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEADBEEF;
        tick(); mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        chk("lw_cmp_valid", cmp_valid, 1);
        chk("lw_cmp_data",  cmp_data, 32'hDEADBEEF);
        chk("lw_cmp_tag",   cmp_tag, 6'd5);
        chk("lw_cmp_pc",    cmp_pc, 32'h1000);
        chk("lw_cmp_lsq",   cmp_from_lsq, 0);
        chk("lw_cmp_store", cmp_is_store, 0);
        chk("lw_issue_rdy_cmp", issue_ready, 0);
        cmp_ready = 1'b1;
        tick(); cmp_ready = 1'b0;
        chk("lw_done_cmp",  cmp_valid, 0);
        chk("lw_done_rdy",  issue_ready, 1);

        // LB 0x203 forwarded from LSQ, byte 3 = 0x80
        issue(OP_LB, 32'h203, 32'h2000, 6'd9, 32'h0, 1'b1, 32'h80123456);
        tick(); issue_valid = 1'b0; issue_fwd_hit = 1'b0;
        chk("lb_no_req",    mem_req_valid, 0);
        chk("lb_cmp_valid", cmp_valid, 1);
        chk("lb_cmp_data",  cmp_data, 32'hFFFFFF80);
        chk("lb_cmp_lsq",   cmp_from_lsq, 1);
        chk("lb_cmp_tag",   cmp_tag, 6'd9);
        cmp_ready = 1'b1;
        tick(); cmp_ready = 1'b0;
        chk("lb_done", cmp_valid, 0);

        // SB 0x302 with ready held low two cycles
        issue(OP_SB, 32'h302, 32'h3000, 6'd12, 32'h000000A5, 1'b0, 32'h0);
        tick(); issue_valid = 1'b0;
        chk("sb_req_be",    mem_req_be, 4'b0100);
        chk("sb_req_wdata", mem_req_wdata, 32'hA5A5A5A5);
        chk("sb_req_we",    mem_req_we, 1);
        chk("sb_req_addr",  mem_req_addr, 32'h300);
        tick();
        chk("sb_hold_valid", mem_req_valid, 1);
        chk("sb_hold_be",    mem_req_be, 4'b0100);
        chk("sb_hold_wdata", mem_req_wdata, 32'hA5A5A5A5);
        mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0;
        chk("sb_cmp_valid", cmp_valid, 1);
        chk("sb_cmp_store", cmp_is_store, 1);
        chk("sb_cmp_data",  cmp_data, 0);
        chk("sb_req_gone",  mem_req_valid, 0);
        cmp_ready = 1'b1;
        tick(); cmp_ready = 1'b0;

        // Misaligned SW and LW
        issue(OP_SW, 32'h401, 32'h4000, 6'd2, 32'h12345678, 1'b0, 32'h0);
        tick(); issue_valid = 1'b0;
        chk("sw_mis_cmp",  cmp_valid, 1);
        chk("sw_mis_flag", cmp_misaligned, 1);
        chk("sw_mis_noreq", mem_req_valid, 0);
        chk("sw_mis_data", cmp_data, 0);
        cmp_ready = 1'b1;
        tick(); cmp_ready = 1'b0;
        issue(OP_LW, 32'h402, 32'h4004, 6'd3, 32'h0, 1'b0, 32'h0);
        tick(); issue_valid = 1'b0;
        chk("lw_mis_cmp",  cmp_valid, 1);
        chk("lw_mis_flag", cmp_misaligned, 1);
        chk("lw_mis_noreq", mem_req_valid, 0);
        chk("lw_mis_data", cmp_data, 0);
        cmp_ready = 1'b1;
        tick(); cmp_ready = 1'b0;

        // LW flushed in WAIT, response drains 2 cycles later
        issue(OP_LW, 32'h500, 32'h5000, 6'd7, 32'h0, 1'b0, 32'h0);
        tick(); issue_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0;
        flush = 1'b1;
        tick(); flush = 1'b0;
        chk("drain_rdy0", issue_ready, 0);
        chk("drain_cmp0", cmp_valid, 0);
        tick();
        chk("drain_rdy1", issue_ready, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBADBAD00;
        tick(); mem_resp_valid = 1'b0;
        chk("drain_done_rdy", issue_ready, 1);
        chk("drain_no_cmp",   cmp_valid, 0);
        issue(OP_LW, 32'h108, 32'h6000, 6'd8, 32'h0, 1'b0, 32'h0);
        tick(); issue_valid = 1'b0;
        chk("next_lw_req", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h11223344;
        tick(); mem_resp_valid = 1'b0;
        chk("next_lw_cmp",  cmp_valid, 1);
        chk("next_lw_data", cmp_data, 32'h11223344);
        chk("next_lw_tag",  cmp_tag, 6'd8);
        cmp_ready = 1'b1;
        tick(); cmp_ready = 1'b0;

        // Stall in CMP, then flush with a competing issue
        issue(OP_LW, 32'h700, 32'h7000, 6'd11, 32'h0, 1'b1, 32'hCAFEF00D);
        tick(); issue_valid = 1'b0; issue_fwd_hit = 1'b0;
        chk("stall_data", cmp_data, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) tick();
        chk("stall_hold", cmp_valid, 1);
        flush = 1'b1;
        issue(OP_SW, 32'h800, 32'h8000, 6'd13, 32'h1, 1'b0, 32'h0);
        chk("flush_issue_rdy", issue_ready, 0);
        tick(); flush = 1'b0; issue_valid = 1'b0;
        chk("flush_cmp_drop", cmp_valid, 0);
        chk("flush_no_req",   mem_req_valid, 0);
        tick();
        chk("flush_not_acc_req", mem_req_valid, 0);
        chk("flush_not_acc_cmp", cmp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
